// File: rtl/branch_resolve_queue.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_queue
// Function : In-order queue of predicted conditional branches between IF and
//            EX; resolves the head against the actual outcome, drives the BHT
//            update port and raises a one-cycle redirect on a misprediction.
//            Optional resolve/mispredict counters are built when BRQ_STATS_EN
//            is defined.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_queue #(
    parameter int DEPTH    = 8,
    parameter int PTR_BITS = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enq_valid,
    input  logic [31:0]         enq_pc,
    input  logic                enq_pred_taken,
    input  logic [31:0]         enq_pred_target,
    output logic                enq_ready,
    input  logic                res_valid,
    input  logic                res_taken,
    input  logic [31:0]         res_target,
    input  logic                flush,
    output logic                update_en,
    output logic [31:0]         update_pc,
    output logic                actual_taken,
    output logic                mispredict,
    output logic [31:0]         redirect_pc,
    output logic [PTR_BITS:0]   count,
    output logic                protocol_err,
    output logic [31:0]         stat_resolved,
    output logic [31:0]         stat_mispred
);

    localparam logic [PTR_BITS:0] C_FULL_COUNT = (PTR_BITS+1)'(DEPTH);

    logic [31:0]        r_pc_mem  [DEPTH];
    logic [31:0]        r_tgt_mem [DEPTH];
    logic [DEPTH-1:0]   r_pt_mem;

    logic [PTR_BITS:0]  r_wr_ptr;
    logic [PTR_BITS:0]  r_rd_ptr;

    logic               r_update_en;
    logic [31:0]        r_update_pc;
    logic               r_actual_taken;
    logic               r_mispredict;
    logic [31:0]        r_redirect_pc;
    logic               r_protocol_err;

    logic [PTR_BITS-1:0] w_wr_idx;
    logic [PTR_BITS-1:0] w_rd_idx;
    logic [PTR_BITS:0]   w_count;
    logic                w_empty;
    logic                w_enq_fire;
    logic                w_res_fire;
    logic [31:0]         w_head_pc;
    logic [31:0]         w_head_tgt;
    logic                w_head_pt;
    logic                w_mis;
    logic                w_clear;

    assign w_wr_idx   = r_wr_ptr[PTR_BITS-1:0];
    assign w_rd_idx   = r_rd_ptr[PTR_BITS-1:0];
    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign enq_ready  = (w_count != C_FULL_COUNT);
    assign w_enq_fire = enq_valid && enq_ready;
    assign w_res_fire = res_valid && !w_empty;

    assign w_head_pc  = r_pc_mem[w_rd_idx];
    assign w_head_tgt = r_tgt_mem[w_rd_idx];
    assign w_head_pt  = r_pt_mem[w_rd_idx];

    // A taken/taken pair still mispredicts when the targets disagree.
    assign w_mis   = (res_taken != w_head_pt) ||
                     (res_taken && w_head_pt && (res_target != w_head_tgt));
    // Flush or a mispredict squashes everything younger, including a same-cycle enqueue.
    assign w_clear = flush || (w_res_fire && w_mis);

    always_ff @(posedge clk) begin
        if (w_enq_fire) begin
            r_pc_mem[w_wr_idx]  <= enq_pc;
            r_tgt_mem[w_wr_idx] <= enq_pred_target;
            r_pt_mem[w_wr_idx]  <= enq_pred_taken;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (w_clear) begin
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (w_enq_fire) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_res_fire) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_update_en    <= 1'b0;
            r_update_pc    <= '0;
            r_actual_taken <= 1'b0;
            r_mispredict   <= 1'b0;
            r_redirect_pc  <= '0;
            r_protocol_err <= 1'b0;
        end else begin
            r_update_en  <= w_res_fire;
            r_mispredict <= w_res_fire && w_mis;
            if (w_res_fire) begin
                r_update_pc    <= w_head_pc;
                r_actual_taken <= res_taken;
                r_redirect_pc  <= res_taken ? res_target : (w_head_pc + 32'd4);
            end
            if (res_valid && w_empty) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

`ifdef BRQ_STATS_EN
    logic [31:0] r_stat_resolved;
    logic [31:0] r_stat_mispred;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_resolved <= '0;
            r_stat_mispred  <= '0;
        end else begin
            if (w_res_fire && (r_stat_resolved != 32'hFFFF_FFFF)) begin
                r_stat_resolved <= r_stat_resolved + 32'd1;
            end
            if (w_res_fire && w_mis && (r_stat_mispred != 32'hFFFF_FFFF)) begin
                r_stat_mispred <= r_stat_mispred + 32'd1;
            end
        end
    end

    assign stat_resolved = r_stat_resolved;
    assign stat_mispred  = r_stat_mispred;
`else
    assign stat_resolved = 32'd0;
    assign stat_mispred  = 32'd0;
`endif

    assign update_en    = r_update_en;
    assign update_pc    = r_update_pc;
    assign actual_taken = r_actual_taken;
    assign mispredict   = r_mispredict;
    assign redirect_pc  = r_redirect_pc;
    assign protocol_err = r_protocol_err;
    assign count        = w_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_queue
// Function : Scoreboard bench for branch_resolve_queue (DEPTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_queue;

    localparam int DEPTH = 8;
    localparam int PB    = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enq_valid = 1'b0;
    logic [31:0] enq_pc = '0;
    logic        enq_pred_taken = 1'b0;
    logic [31:0] enq_pred_target = '0;
    logic        enq_ready;
    logic        res_valid = 1'b0;
    logic        res_taken = 1'b0;
    logic [31:0] res_target = '0;
    logic        flush = 1'b0;
    logic        update_en;
    logic [31:0] update_pc;
    logic        actual_taken;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [PB:0] count;
    logic        protocol_err;
    logic [31:0] stat_resolved;
    logic [31:0] stat_mispred;

    branch_resolve_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_pred_taken(enq_pred_taken),
        .enq_pred_target(enq_pred_target), .enq_ready(enq_ready),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .flush(flush), .update_en(update_en), .update_pc(update_pc),
        .actual_taken(actual_taken), .mispredict(mispredict), .redirect_pc(redirect_pc),
        .count(count), .protocol_err(protocol_err),
        .stat_resolved(stat_resolved), .stat_mispred(stat_mispred)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic        mis;
        logic [31:0] redir;
    } upd_t;

    upd_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_upd(input logic [31:0] pc, input logic taken,
                              input logic mis, input logic [31:0] redir);
        upd_t u;
        u.pc = pc; u.taken = taken; u.mis = mis; u.redir = redir;
        sb.push_back(u);
    endtask

    // Monitor: every update pulse must match the oldest expected resolve.
    always @(negedge clk) begin
        if (!reset) begin
            if (update_en) begin
                if (sb.size() == 0) begin
                    chk("unexpected_update_en", 32'(update_en), 32'd0);
                end else begin
                    upd_t u;
                    u = sb.pop_front();
                    chk("update_pc", update_pc, u.pc);
                    chk("actual_taken", 32'(actual_taken), 32'(u.taken));
                    chk("mispredict", 32'(mispredict), 32'(u.mis));
                    if (u.mis) chk("redirect_pc", redirect_pc, u.redir);
                end
            end else begin
                chk("mispredict_without_update", 32'(mispredict), 32'd0);
            end
        end
    end

    // One clock cycle of stimulus, driven just after the rising edge.
    task automatic drive(input logic ev, input logic [31:0] epc, input logic ept,
                         input logic [31:0] etgt, input logic rv, input logic rt,
                         input logic [31:0] rtgt, input logic fl);
        enq_valid = ev; enq_pc = epc; enq_pred_taken = ept; enq_pred_target = etgt;
        res_valid = rv; res_taken = rt; res_target = rtgt; flush = fl;
        @(posedge clk); #1;
        enq_valid = 1'b0; res_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic enq(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
        drive(1'b1, pc, pt, tgt, 1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    logic [31:0] mq[$];
    logic [31:0] next_pc;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_enq_ready", 32'(enq_ready), 32'd1);
        chk("rst_update_en", 32'(update_en), 32'd0);
        chk("rst_protocol_err", 32'(protocol_err), 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Correct not-taken resolve
        enq(32'h100, 1'b0, 32'h0);
        chk("count_after_enq", 32'(count), 32'd1);
        expect_upd(32'h100, 1'b0, 1'b0, 32'h104);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("count_after_res", 32'(count), 32'd0);

        // Direction mispredict with same-cycle enqueue dropped
        enq(32'h200, 1'b0, 32'h0);
        expect_upd(32'h200, 1'b1, 1'b1, 32'h240);
        drive(1'b1, 32'h999, 1'b0, 32'h0, 1'b1, 1'b1, 32'h240, 1'b0);
        chk("count_after_mispred", 32'(count), 32'd0);

        // Target mispredict, then taken-predicted but not taken
        enq(32'h300, 1'b1, 32'h380);
        expect_upd(32'h300, 1'b1, 1'b1, 32'h390);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h390, 1'b0);
        enq(32'h300, 1'b1, 32'h380);
        expect_upd(32'h300, 1'b0, 1'b1, 32'h304);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        enq(32'h400, 1'b1, 32'h480);
        expect_upd(32'h400, 1'b1, 1'b0, 32'h480);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h480, 1'b0);
        chk("count_after_correct_taken", 32'(count), 32'd0);

        // Fill, reject 9th, then steady-state resolve+enqueue across wrap
        for (int i = 0; i < DEPTH; i++) begin
            enq(32'h1000 + 32'(4 * i), 1'b0, 32'h0);
            mq.push_back(32'h1000 + 32'(4 * i));
        end
        chk("full_count", 32'(count), 32'd8);
        chk("full_enq_ready", 32'(enq_ready), 32'd0);
        enq(32'hDEAD, 1'b0, 32'h0);
        chk("ninth_rejected_count", 32'(count), 32'd8);
        next_pc = 32'h2000;
        for (int c = 0; c < 20; c++) begin
            logic was_full;
            logic [31:0] hp;
            was_full = (mq.size() == DEPTH);
            hp = mq.pop_front();
            expect_upd(hp, 1'b0, 1'b0, hp + 32'd4);
            drive(1'b1, next_pc, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
            if (!was_full) begin
                mq.push_back(next_pc);
                next_pc = next_pc + 32'd4;
            end
            chk("wrap_count", 32'(count), 32'(mq.size()));
        end
        while (mq.size() > 0) begin
            logic [31:0] hp;
            hp = mq.pop_front();
            expect_upd(hp, 1'b0, 1'b0, hp + 32'd4);
            drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        end
        chk("drained_count", 32'(count), 32'd0);

        // Resolve on empty queue
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h50, 1'b0);
        chk("protocol_err_set", 32'(protocol_err), 32'd1);
        @(posedge clk); #1;
        chk("protocol_err_sticky", 32'(protocol_err), 32'd1);

        // Flush with 3 entries plus same-cycle correct resolve
        enq(32'h500, 1'b0, 32'h0);
        enq(32'h504, 1'b0, 32'h0);
        enq(32'h508, 1'b0, 32'h0);
        chk("pre_flush_count", 32'(count), 32'd3);
        expect_upd(32'h500, 1'b0, 1'b0, 32'h504);
        drive(1'b1, 32'h600, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("post_flush_count", 32'(count), 32'd0);
        @(posedge clk); #1;
        chk("protocol_err_still", 32'(protocol_err), 32'd1);

        // Reset mid-stream: outputs drop without waiting for a clock edge
        enq(32'h900, 1'b1, 32'h980);
        enq(32'h904, 1'b0, 32'h0);
        chk("pre_reset_count", 32'(count), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_enq_ready", 32'(enq_ready), 32'd1);
        chk("midrst_protocol_err", 32'(protocol_err), 32'd0);
        chk("midrst_update_pc", update_pc, 32'd0);
        chk("midrst_redirect_pc", redirect_pc, 32'd0);
        chk("midrst_stat_resolved", stat_resolved, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Five resolves, two of them mispredicts
        enq(32'h700, 1'b0, 32'h0);
        expect_upd(32'h700, 1'b0, 1'b0, 32'h704);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        enq(32'h704, 1'b1, 32'h800);
        expect_upd(32'h704, 1'b1, 1'b0, 32'h800);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h800, 1'b0);
        enq(32'h708, 1'b0, 32'h0);
        expect_upd(32'h708, 1'b1, 1'b1, 32'h900);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h900, 1'b0);
        enq(32'h70C, 1'b1, 32'h880);
        expect_upd(32'h70C, 1'b0, 1'b1, 32'h710);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        enq(32'h710, 1'b0, 32'h0);
        expect_upd(32'h710, 1'b0, 1'b0, 32'h714);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
`ifdef BRQ_STATS_EN
        chk("stat_resolved", stat_resolved, 32'd5);
        chk("stat_mispred", stat_mispred, 32'd2);
`else
        chk("stat_resolved_tied", stat_resolved, 32'd0);
        chk("stat_mispred_tied", stat_mispred, 32'd0);
`endif
        chk("final_protocol_err", 32'(protocol_err), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Tracks every conditional branch from fetch (prediction time) to execute (resolution time) in program order.
- On resolution, drives the update port of the 2-bit branch history table (update_en / update_pc / actual_taken).
- Detects a misprediction and issues a one-cycle redirect to fetch.
- Sits between IF (enqueue side) and EX (resolve side) of the pipelined core.

Parameters:
- DEPTH, 8, queue entries; power of 2, at least 2.
- PTR_BITS, $clog2(DEPTH), index width; pointers carry one extra wrap bit.

Ports:
- clk  input  1  core clock.
- reset  input  1  asynchronous, active-high reset.
- enq_valid  input  1  IF presents a predicted conditional branch.
- enq_pc  input  32  branch PC.
- enq_pred_taken  input  1  predictor direction.
- enq_pred_target  input  32  predicted target; only meaningful when enq_pred_taken=1.
- enq_ready  output  1  queue not full; combinational from count.
- res_valid  input  1  EX resolves the oldest outstanding branch.
- res_taken  input  1  actual direction.
- res_target  input  32  actual taken target.
- flush  input  1  external pipeline flush (trap, jal redirect); discards all entries.
- update_en  output  1  registered; one-cycle pulse to BHT.
- update_pc  output  32  registered; PC of the resolved branch.
- actual_taken  output  1  registered; resolved direction.
- mispredict  output  1  registered; one-cycle pulse.
- redirect_pc  output  32  registered; correct next PC, valid when mispredict=1.
- count  output  PTR_BITS+1  current occupancy.
- protocol_err  output  1  sticky; set when res_valid arrives while the queue is empty.
- stat_resolved  output  32  see Optional Feature.
- stat_mispred  output  32  see Optional Feature.

Behaviour:
- Reset (async): wr_ptr=rd_ptr=0, count=0. All registered outputs 0, protocol_err 0, stats 0. Entry storage need not be cleared.
- Storage: circular FIFO with entry fields {pc, pred_taken, pred_target}.
- Full: wr_ptr and rd_ptr differ only in the MSB. Empty: pointers are equal.
- enq_ready = (count != DEPTH). Enqueue is accepted when enq_valid && enq_ready.
- Full queue with a simultaneous resolve: the enqueue is still rejected, because enq_ready does not look ahead.
- Resolve (res_valid && !empty): pops the head. On the next clk edge:
  - update_en=1, update_pc=head.pc, actual_taken=res_taken.
  - mispredict = (res_taken != head.pred_taken) || (res_taken && head.pred_taken && res_target != head.pred_target).
  - redirect_pc = res_taken ? res_target : head.pc + 32'd4 (modulo 2^32).
  - Latency from res_valid to update_en is exactly 1 cycle.
- res_valid while empty: no pop, no update, protocol_err set to 1 until reset.
- Mispredict resolve: the queue is cleared on the same edge (wr_ptr=rd_ptr, count=0). A same-cycle enqueue is dropped because it is wrong-path.
- flush=1: queue cleared on that edge, same-cycle enqueue dropped.
  - A same-cycle valid resolve is still processed first: update and mispredict outputs are emitted as normal.
  - If the queue was already empty, flush has no other effect.
- Simultaneous enqueue and correct resolve, not full: both take effect and count is unchanged.
- Pointer wrap: indices wrap modulo DEPTH and the wrap bit toggles.
- update_en, mispredict and protocol_err are deasserted in every cycle without a valid resolve; protocol_err excepted once set.
- Reset asserted mid-operation: all state discarded immediately and all outputs forced to reset values.

Optional Feature:
- Macro: BRQ_STATS_EN.
- Defined:
  - stat_resolved increments on each valid resolve.
  - stat_mispred increments on each mispredicting resolve.
  - Both counters are 32-bit, saturate at 32'hFFFF_FFFF, update on the same edge as update_en, and reset to 0.
- Undefined: counter logic is not instantiated and both stat ports are tied to 32'd0. The port list is unchanged.

Test Plan:
- Enqueue pc=0x100, pred_taken=0; resolve res_taken=0 -> next cycle update_en=1, update_pc=0x100, actual_taken=0, mispredict=0, count=0.
- Enqueue pc=0x200, pred_taken=0; resolve res_taken=1, res_target=0x240 -> mispredict=1, redirect_pc=0x240, update_en=1; enqueue offered in the same cycle is dropped, count=0.
- Enqueue pc=0x300, pred_taken=1, pred_target=0x380; resolve res_taken=1, res_target=0x390 -> mispredict=1, redirect_pc=0x390. Repeat with pred_taken=1, res_taken=0 -> redirect_pc=0x304.
- Enqueue 8 branches (DEPTH=8) -> enq_ready=0 and a 9th enqueue is rejected. Do resolve and enqueue in the same cycle repeatedly for 20 cycles -> pointers wrap, update_pc stream is in exact enqueue order, count stays 8 then 7 as appropriate.
- res_valid with the queue empty -> no update_en, protocol_err=1 and it remains 1. Flush with 3 entries plus a same-cycle correct resolve -> one update emitted, then count=0.
- With BRQ_STATS_EN: 5 resolves including 2 mispredicts -> stat_resolved=5, stat_mispred=2. Assert reset mid-stream -> all outputs and stats are 0 immediately.
